// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
// One transaction outstanding at a time; a wait timeout aborts and still answers the requester.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_resp,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_resp,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERROR} state_t;

  state_t            state;
  logic              last_grant;
  logic              gnt_id;
  logic              gnt_wr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;

  logic c0_bad, c1_bad, c0_req, c1_req, pick1;

  // A port driving read and write together is excluded from arbitration.
  assign c0_bad = c0_read & c0_write;
  assign c1_bad = c1_read & c1_write;
  assign c0_req = (c0_read | c0_write) & ~c0_bad;
  assign c1_req = (c1_read | c1_write) & ~c1_bad;
  assign pick1  = c1_req & (~c0_req | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      gnt_wr     <= 1'b0;
      cnt        <= '0;
      rdata_q    <= '0;
      c0_resp    <= 1'b0;
      c0_rdata   <= '0;
      c1_resp    <= 1'b0;
      c1_rdata   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      error      <= 1'b0;
    end else begin
      c0_resp  <= 1'b0;
      c1_resp  <= 1'b0;
      c0_rdata <= '0;
      c1_rdata <= '0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          if (c0_bad || c1_bad || mem_resp) error <= 1'b1;
          if (c0_req || c1_req) begin
            gnt_id     <= pick1;
            gnt_wr     <= pick1 ? c1_write : c0_write;
            mem_addr   <= pick1 ? c1_addr : c0_addr;
            mem_wdata  <= pick1 ? c1_wdata : c0_wdata;
            last_grant <= pick1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_resp) error <= 1'b1;
          mem_read  <= ~gnt_wr;
          mem_write <= gnt_wr;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata_q   <= gnt_wr ? '0 : mem_rdata;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata_q   <= '0;
            state     <= ERROR;
          end
        end
        RESP: begin
          if (mem_resp) error <= 1'b1;
          if (gnt_id) begin
            c1_resp  <= 1'b1;
            c1_rdata <= rdata_q;
          end else begin
            c0_resp  <= 1'b1;
            c0_rdata <= rdata_q;
          end
          state <= IDLE;
        end
        ERROR: begin
          // Answer the requester with zero data so its FSM cannot hang.
          error <= 1'b1;
          if (gnt_id) c1_resp <= 1'b1;
          else        c0_resp <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         c0_read = 1'b0, c0_write = 1'b0, c1_read = 1'b0, c1_write = 1'b0;
  logic [31:0]  c0_addr = '0, c1_addr = '0;
  logic [127:0] c0_wdata = '0, c1_wdata = '0;
  logic         c0_resp, c1_resp;
  logic [127:0] c0_rdata, c1_rdata;
  logic         mem_read, mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;
  logic         error;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(128), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_read(c0_read), .c0_write(c0_write), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_resp(c0_resp), .c0_rdata(c0_rdata),
    .c1_read(c1_read), .c1_write(c1_write), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_resp(c1_resp), .c1_rdata(c1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .error(error)
  );

  typedef struct {
    bit           port;
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  typedef struct {
    bit           port;
    logic [127:0] rdata;
    bit           err;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  mem_exp_t  cur;

  int total = 0, passed = 0, cyc = 0, err_cnt = 0, high_cnt = 0;
  int strobe_cyc = 0, resp_cyc = 0, mresp_cyc = 0, req_cyc = 0, wait_cnt = 0;
  int resp_delay = 3;
  bit auto_en = 1'b0, prev_s = 1'b0, r0_seen = 1'b0, r1_seen = 1'b0, s_rise = 1'b0;

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: observe outputs at negedge, score them, then drive the memory model.
  task automatic tick();
    mem_exp_t  e;
    resp_exp_t r;
    logic      s;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    s       = mem_read | mem_write;
    r0_seen = c0_resp;
    r1_seen = c1_resp;
    s_rise  = s && !prev_s;
    if (error) err_cnt++;
    if (s) high_cnt++;
    if (s_rise) begin
      strobe_cyc = cyc;
      wait_cnt   = 0;
      chk("strobe_exclusive", 128'(mem_read & mem_write), 128'(0));
      if (mem_q.size() == 0) begin
        chk("unexpected_strobe", 128'(s), 128'(0));
      end else begin
        e   = mem_q.pop_front();
        cur = e;
        chk("mem_write_op", 128'(mem_write), 128'(e.wr));
        chk("mem_addr", 128'(mem_addr), 128'(e.addr));
        if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
    prev_s = s;
    if (c0_resp || c1_resp) begin
      resp_cyc = cyc;
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 128'({c1_resp, c0_resp}), 128'(0));
      end else begin
        r = resp_q.pop_front();
        chk("resp_port", 128'({c1_resp, c0_resp}), r.port ? 128'(2) : 128'(1));
        chk("resp_rdata", r.port ? c1_rdata : c0_rdata, r.rdata);
        chk("other_rdata_zero", r.port ? c0_rdata : c1_rdata, 128'(0));
        chk("resp_error", 128'(error), 128'(r.err));
      end
    end
    if (mem_resp) begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
    end else if (s && auto_en) begin
      wait_cnt++;
      if (wait_cnt == resp_delay) begin
        mem_resp  = 1'b1;
        mresp_cyc = cyc;
        mem_rdata = cur.wr ? {4{$urandom}} : data_of(cur.addr);
        r.port  = cur.port;
        r.rdata = cur.wr ? 128'(0) : data_of(cur.addr);
        r.err   = 1'b0;
        resp_q.push_back(r);
      end
    end
  endtask

  task automatic wait_resp(input bit port, input int limit, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      got = port ? r1_seen : r0_seen;
    end
    chk(tag, 128'(got), 128'(1));
  endtask

  task automatic wait_rise(input int limit, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      got = s_rise;
    end
    chk(tag, 128'(got), 128'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c0_read = 1'b0; c0_write = 1'b0; c1_read = 1'b0; c1_write = 1'b0;
    mem_resp = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int e0, m, n0, n1;
    logic [127:0] wd [3];

    // Reset state
    tick();
    tick();
    chk("rst_strobes_resp_err", 128'({mem_read, mem_write, c0_resp, c1_resp, error}), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_rdata", c0_rdata | c1_rdata, 128'(0));
    rst_n = 1'b1;

    // Single port-0 read with latency checks
    auto_en = 1'b1; resp_delay = 3;
    c0_addr = 32'h100; c0_read = 1'b1; req_cyc = cyc;
    mem_q.push_back('{port: 1'b0, wr: 1'b0, addr: 32'h100, wdata: '0});
    wait_resp(1'b0, 30, "t1_resp_wait");
    c0_read = 1'b0;
    chk("t1_strobe_latency", 128'(strobe_cyc - req_cyc), 128'(2));
    chk("t1_resp_latency", 128'(resp_cyc - mresp_cyc), 128'(2));
    chk("t1_strobe_dropped", 128'(mem_read), 128'(0));

    // Tie from reset: port 0 write first, then port 1; next tie goes to port 1
    do_reset();
    c0_write = 1'b1; c0_addr = 32'h200; c0_wdata = {4{32'hDEADBEEF}};
    c1_read = 1'b1; c1_addr = 32'h300;
    mem_q.push_back('{port: 1'b0, wr: 1'b1, addr: 32'h200, wdata: {4{32'hDEADBEEF}}});
    mem_q.push_back('{port: 1'b1, wr: 1'b0, addr: 32'h300, wdata: '0});
    mem_q.push_back('{port: 1'b0, wr: 1'b0, addr: 32'h400, wdata: '0});
    wait_resp(1'b0, 30, "t2_p0_wait");
    m = mresp_cyc;
    c0_write = 1'b0; c0_read = 1'b1; c0_addr = 32'h400;
    wait_rise(10, "t2_p1_strobe_wait");
    chk("t2_regrant_latency", 128'(strobe_cyc - m), 128'(4));
    wait_resp(1'b1, 30, "t2_p1_wait");
    c1_read = 1'b0;
    wait_resp(1'b0, 30, "t2_p0b_wait");
    c0_read = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1,0,1
    do_reset();
    resp_delay = 2;
    for (int i = 0; i < 3; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_q.push_back('{port: 1'b0, wr: 1'b0, addr: 32'h1000 + 32'(i * 16), wdata: '0});
      mem_q.push_back('{port: 1'b1, wr: 1'b1, addr: 32'h2000 + 32'(i * 16), wdata: wd[i]});
    end
    c0_read = 1'b1; c0_addr = 32'h1000;
    c1_write = 1'b1; c1_addr = 32'h2000; c1_wdata = wd[0];
    n0 = 0; n1 = 0;
    for (int i = 0; i < 200 && (n0 < 3 || n1 < 3); i++) begin
      tick();
      if (r0_seen) begin
        n0++;
        if (n0 < 3) c0_addr = 32'h1000 + 32'(n0 * 16);
        else c0_read = 1'b0;
      end
      if (r1_seen) begin
        n1++;
        if (n1 < 3) begin
          c1_addr = 32'h2000 + 32'(n1 * 16);
          c1_wdata = wd[n1];
        end else c1_write = 1'b0;
      end
    end
    chk("t3_completed", 128'(n0 + n1), 128'(6));

    // Timeout on port 1, then a normal transaction
    do_reset();
    auto_en = 1'b0; resp_delay = 3;
    c1_read = 1'b1; c1_addr = 32'h500;
    mem_q.push_back('{port: 1'b1, wr: 1'b0, addr: 32'h500, wdata: '0});
    resp_q.push_back('{port: 1'b1, rdata: '0, err: 1'b1});
    high_cnt = 0; e0 = err_cnt;
    wait_resp(1'b1, 40, "t4_timeout_wait");
    c1_read = 1'b0;
    chk("t4_strobe_cycles", 128'(high_cnt), 128'(8));
    chk("t4_error_pulses", 128'(err_cnt - e0), 128'(1));
    auto_en = 1'b1;
    c1_write = 1'b1; c1_addr = 32'h600; c1_wdata = {4{32'h12345678}};
    mem_q.push_back('{port: 1'b1, wr: 1'b1, addr: 32'h600, wdata: {4{32'h12345678}}});
    wait_resp(1'b1, 30, "t4_next_wait");
    c1_write = 1'b0;
    chk("t4_no_extra_error", 128'(err_cnt - e0), 128'(1));

    // Protocol violations: read&write on one port, spurious mem_resp in IDLE
    do_reset();
    e0 = err_cnt; high_cnt = 0;
    c0_read = 1'b1; c0_write = 1'b1;
    tick();
    c0_read = 1'b0; c0_write = 1'b0;
    chk("t5_rw_error", 128'(error), 128'(1));
    tick();
    tick();
    chk("t5_rw_error_count", 128'(err_cnt - e0), 128'(1));
    mem_resp = 1'b1;
    tick();
    chk("t5_spurious_error", 128'(error), 128'(1));
    tick();
    tick();
    chk("t5_error_count", 128'(err_cnt - e0), 128'(2));
    chk("t5_no_strobe", 128'(high_cnt), 128'(0));

    // Asynchronous reset during WAIT, then fresh tie goes to port 0
    do_reset();
    auto_en = 1'b0;
    c1_read = 1'b1; c1_addr = 32'h900;
    mem_q.push_back('{port: 1'b1, wr: 1'b0, addr: 32'h900, wdata: '0});
    wait_rise(10, "t6_strobe_wait");
    tick();
    chk("t6_strobe_held", 128'(mem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1 chk("t6_async_drop", 128'(mem_read), 128'(0));
    c1_read = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    auto_en = 1'b1;
    c0_read = 1'b1; c0_addr = 32'h700;
    c1_read = 1'b1; c1_addr = 32'h800;
    mem_q.push_back('{port: 1'b0, wr: 1'b0, addr: 32'h700, wdata: '0});
    mem_q.push_back('{port: 1'b1, wr: 1'b0, addr: 32'h800, wdata: '0});
    wait_resp(1'b0, 30, "t6_p0_wait");
    c0_read = 1'b0;
    wait_resp(1'b1, 30, "t6_p1_wait");
    c1_read = 1'b0;
    tick();

    chk("mem_q_drained", 128'(mem_q.size()), 128'(0));
    chk("resp_q_drained", 128'(resp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
